// File: rtl/arm_pkg.sv
// Shared types for the ARMv4 fetch front end: FSM states, instruction field
// positions and the FIFO entry format.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int COND_MSB       = 31;
  localparam int COND_LSB       = 28;
  localparam int OP_MSB         = 27;
  localparam int OP_LSB         = 26;
  localparam int FUNCT_MSB      = 25;
  localparam int FUNCT_LSB      = 20;
  localparam int RD_MSB         = 15;
  localparam int RD_LSB         = 12;
  localparam int SHAMT_MSB      = 11;
  localparam int SHAMT_LSB      = 7;
  localparam int SH_MSB         = 6;
  localparam int SH_LSB         = 5;
  localparam int SHIFT_TYPE_BIT = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Redirect targets are always word addresses.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with a flush that
// overrides any same-cycle push or pop. Head reads back as all zeros when empty.
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_entry,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push & ~flush & (~full | pop);
  assign do_pop  = pop & ~flush & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, single-outstanding imem reads,
// redirect handling and field slicing of the buffered head instruction.
module fetch_unit
  import arm_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic        wb_pc_valid,
  input  logic [31:0] wb_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  output logic [3:0]  cond,
  output logic [1:0]  op,
  output logic [5:0]  funct,
  output logic [3:0]  rd,
  output logic [4:0]  shamt5,
  output logic [1:0]  sh,
  output logic        shift_type
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          redir;
  logic [31:0]   new_pc;
  logic          push;
  logic          pop;
  logic          space;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          fifo_empty;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign redir       = wb_pc_valid | br_valid;
  assign new_pc      = align_word(wb_pc_valid ? wb_pc : br_pc);
  assign pop         = dec_valid & dec_ready;
  assign space       = (count < CW'(FIFO_DEPTH));
  assign count_after = count + CW'(1) - CW'(pop);
  assign push_entry  = '{instr: imem_rdata, pc: req_addr_q};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    imem_req   = 1'b0;
    if (redir) pc_d = new_pc;
    case (state_q)
      IDLE: begin
        if (redir || space) begin
          state_d    = REQ;
          req_addr_d = redir ? new_pc : pc_q;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (!redir) begin
            push = 1'b1;
            pc_d = req_addr_q + 32'd4;
            // Keep streaming only while the word just pushed leaves a free slot.
            if (count_after < CW'(FIFO_DEPTH)) begin
              req_addr_d = req_addr_q + 32'd4;
            end else begin
              state_d = IDLE;
            end
          end else begin
            req_addr_d = new_pc;
          end
        end else if (redir) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The stale read must complete at its original address before refetching.
        imem_req = 1'b1;
        if (imem_ack) begin
          state_d    = REQ;
          req_addr_d = redir ? new_pc : pc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redir),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty)
  );

  assign imem_addr  = req_addr_q;
  assign dec_valid  = ~fifo_empty;
  assign instr      = head.instr;
  assign instr_pc   = head.pc;
  assign pc_plus8   = head.pc + 32'd8;
  assign cond       = head.instr[COND_MSB:COND_LSB];
  assign op         = head.instr[OP_MSB:OP_LSB];
  assign funct      = head.instr[FUNCT_MSB:FUNCT_LSB];
  assign rd         = head.instr[RD_MSB:RD_LSB];
  assign shamt5     = head.instr[SHAMT_MSB:SHAMT_LSB];
  assign sh         = head.instr[SH_MSB:SH_LSB];
  assign shift_type = head.instr[SHIFT_TYPE_BIT];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against an instruction-stream model of the fetch front end.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        br_valid;
  logic [31:0] br_pc;
  logic        wb_pc_valid;
  logic [31:0] wb_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic [3:0]  cond;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  rd;
  logic [4:0]  shamt5;
  logic [1:0]  sh;
  logic        shift_type;
  logic        ack_en;

  int n_cmp;
  int n_err;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = mem_word(imem_addr);

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (32'h0),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .br_valid   (br_valid),
    .br_pc      (br_pc),
    .wb_pc_valid(wb_pc_valid),
    .wb_pc      (wb_pc),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .pc_plus8   (pc_plus8),
    .cond       (cond),
    .op         (op),
    .funct      (funct),
    .rd         (rd),
    .shamt5     (shamt5),
    .sh         (sh),
    .shift_type (shift_type)
  );

  task automatic clear_inputs();
    br_valid    = 1'b0;
    br_pc       = 32'h0;
    wb_pc_valid = 1'b0;
    wb_pc       = 32'h0;
  endtask

  // Returns on the falling edge at which reset is released (cycle 0).
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ack_en = 1'b0;
    dec_ready = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || dec_valid !== 1'b0 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_ctrl: got req=%b dec_valid=%b addr=%h, want 0 0 00000000", imem_req, dec_valid, imem_addr);
    end
    n_cmp++;
    if (instr !== 32'h0 || instr_pc !== 32'h0 || cond !== 4'h0 || op !== 2'h0 || funct !== 6'h0 ||
        rd !== 4'h0 || shamt5 !== 5'h0 || sh !== 2'h0 || shift_type !== 1'b0) begin
      n_err++;
      $display("FAIL reset_head: got instr=%h pc=%h cond=%h op=%h funct=%h rd=%h, want all zero", instr, instr_pc, cond, op, funct, rd);
    end
    $display("test_reset: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    logic [31:0] exp_ipc;
    ack_en = 1'b1;
    dec_ready = 1'b1;
    apply_reset();
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_addr = 32'(4 * (c - 1));
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
        n_err++;
        $display("FAIL stream_addr c=%0d: got req=%b addr=%h, want req=1 addr=%h", c, imem_req, imem_addr, exp_addr);
      end
      n_cmp++;
      if (c < 2) begin
        if (dec_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stream_first_valid c=%0d: got dec_valid=%b, want 0", c, dec_valid);
        end
      end else begin
        exp_ipc = 32'(4 * (c - 2));
        if (dec_valid !== 1'b1 || instr_pc !== exp_ipc || instr !== mem_word(exp_ipc) || pc_plus8 !== exp_ipc + 32'd8) begin
          n_err++;
          $display("FAIL stream_head c=%0d: got v=%b pc=%h instr=%h p8=%h, want v=1 pc=%h instr=%h p8=%h",
                   c, dec_valid, instr_pc, instr, pc_plus8, exp_ipc, mem_word(exp_ipc), exp_ipc + 32'd8);
        end
      end
    end
    $display("test_stream: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic        seen;
    logic [31:0] first_addr;
    ack_en = 1'b1;
    dec_ready = 1'b0;
    apply_reset();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (c <= 2) begin
        if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (c - 1))) begin
          n_err++;
          $display("FAIL bp_fill c=%0d: got req=%b addr=%h, want req=1 addr=%h", c, imem_req, imem_addr, 32'(4 * (c - 1)));
        end
      end else if (imem_req !== 1'b0 || dec_valid !== 1'b1 || instr_pc !== 32'h0) begin
        n_err++;
        $display("FAIL bp_full c=%0d: got req=%b v=%b pc=%h, want req=0 v=1 pc=00000000", c, imem_req, dec_valid, instr_pc);
      end
    end
    dec_ready = 1'b1;
    seen = 1'b0;
    first_addr = 32'h0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (dec_valid) got.push_back(instr_pc);
      if (imem_req && !seen) begin
        seen = 1'b1;
        first_addr = imem_addr;
      end
    end
    n_cmp++;
    if (got.size() < 3) begin
      n_err++;
      $display("FAIL bp_drain_count: got %0d words, want at least 3", got.size());
    end else if (got[0] !== 32'h0 || got[1] !== 32'h4 || got[2] !== 32'h8) begin
      n_err++;
      $display("FAIL bp_drain_order: got %h %h %h, want 00000000 00000004 00000008", got[0], got[1], got[2]);
    end
    n_cmp++;
    if (!seen || first_addr !== 32'h8) begin
      n_err++;
      $display("FAIL bp_resume: got seen=%b addr=%h, want seen=1 addr=00000008", seen, first_addr);
    end
    $display("test_backpressure: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_branch_drain();
    ack_en = 1'b0;
    dec_ready = 1'b1;
    apply_reset();
    @(negedge clk);
    br_valid = 1'b1;
    br_pc = 32'h100;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 4) ack_en = 1'b1;
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || dec_valid !== 1'b0) begin
        n_err++;
        $display("FAIL drain_hold c=%0d: got req=%b addr=%h v=%b, want req=1 addr=00000000 v=0", c, imem_req, imem_addr, dec_valid);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || dec_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_refetch: got req=%b addr=%h v=%b, want req=1 addr=00000100 v=0", imem_req, imem_addr, dec_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (dec_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
      n_err++;
      $display("FAIL drain_target: got v=%b pc=%h instr=%h, want v=1 pc=00000100 instr=%h", dec_valid, instr_pc, instr, mem_word(32'h100));
    end
    $display("test_branch_drain: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_dual_redirect();
    ack_en = 1'b1;
    dec_ready = 1'b0;
    apply_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b0 || dec_valid !== 1'b1) begin
      n_err++;
      $display("FAIL dual_setup: got req=%b v=%b, want req=0 v=1", imem_req, dec_valid);
    end
    br_valid = 1'b1;
    br_pc = 32'h200;
    wb_pc_valid = 1'b1;
    wb_pc = 32'h300;
    @(negedge clk);
    clear_inputs();
    dec_ready = 1'b1;
    n_cmp++;
    if (dec_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      n_err++;
      $display("FAIL dual_flush: got v=%b req=%b addr=%h, want v=0 req=1 addr=00000300", dec_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (dec_valid !== 1'b1 || instr_pc !== 32'h300) begin
      n_err++;
      $display("FAIL dual_target: got v=%b pc=%h, want v=1 pc=00000300", dec_valid, instr_pc);
    end
    $display("test_dual_redirect: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_redir_ack();
    ack_en = 1'b1;
    dec_ready = 1'b1;
    apply_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (imem_addr !== 32'h8 || dec_valid !== 1'b1 || instr_pc !== 32'h4) begin
      n_err++;
      $display("FAIL rack_setup: got addr=%h v=%b pc=%h, want addr=00000008 v=1 pc=00000004", imem_addr, dec_valid, instr_pc);
    end
    br_valid = 1'b1;
    br_pc = 32'h403;
    @(negedge clk);
    clear_inputs();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h400 || dec_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rack_next: got req=%b addr=%h v=%b, want req=1 addr=00000400 v=0", imem_req, imem_addr, dec_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (dec_valid !== 1'b1 || instr_pc !== 32'h400 || imem_addr !== 32'h404) begin
      n_err++;
      $display("FAIL rack_target: got v=%b pc=%h addr=%h, want v=1 pc=00000400 addr=00000404", dec_valid, instr_pc, imem_addr);
    end
    $display("test_redir_ack: done, %0d compared so far", n_cmp);
  endtask

  task automatic test_reset_drain_wrap();
    ack_en = 1'b1;
    dec_ready = 1'b1;
    apply_reset();
    repeat (3) @(negedge clk);
    ack_en = 1'b0;
    br_valid = 1'b1;
    br_pc = 32'h80;
    @(negedge clk);
    clear_inputs();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_err++;
      $display("FAIL rst_drain_setup: got req=%b addr=%h, want req=1 addr=00000008", imem_req, imem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (imem_req !== 1'b0 || dec_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: got req=%b v=%b, want req=0 v=0", imem_req, dec_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_refetch: got req=%b addr=%h, want req=1 addr=00000000", imem_req, imem_addr);
    end
    wb_pc_valid = 1'b1;
    wb_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    clear_inputs();
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_addr: got addr=%h, want fffffffc", imem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (imem_addr !== 32'h0 || dec_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || pc_plus8 !== 32'h4) begin
      n_err++;
      $display("FAIL wrap_head: got addr=%h v=%b pc=%h p8=%h, want addr=00000000 v=1 pc=fffffffc p8=00000004",
               imem_addr, dec_valid, instr_pc, pc_plus8);
    end
    @(negedge clk);
    n_cmp++;
    if (dec_valid !== 1'b1 || instr_pc !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_next: got v=%b pc=%h, want v=1 pc=00000000", dec_valid, instr_pc);
    end
    $display("test_reset_drain_wrap: done, %0d compared so far", n_cmp);
  endtask

  // Model: decode must see the exact address stream RESET_PC, +4, ... restarting
  // at each aligned redirect target, each word matching memory, and the bus must
  // hold its address until acknowledged.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic [31:0] w;
    logic [31:0] prev_addr;
    logic        prev_wait;
    logic        redir;
    int          gap;
    int          delivered;
    ack_en = 1'b0;
    dec_ready = 1'b0;
    apply_reset();
    exp_pc = 32'h0;
    prev_wait = 1'b0;
    prev_addr = 32'h0;
    gap = 0;
    delivered = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (prev_wait) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_err++;
          $display("FAIL rnd_addr_stable cyc=%0d: got req=%b addr=%h, want req=1 addr=%h", cyc, imem_req, imem_addr, prev_addr);
        end
      end
      if (dec_valid) begin
        w = mem_word(instr_pc);
        n_cmp++;
        if (instr !== w || pc_plus8 !== instr_pc + 32'd8 || cond !== w[31:28] || op !== w[27:26] ||
            funct !== w[25:20] || rd !== w[15:12] || shamt5 !== w[11:7] || sh !== w[6:5] || shift_type !== w[4]) begin
          n_err++;
          $display("FAIL rnd_fields cyc=%0d pc=%h: got instr=%h p8=%h c=%h o=%h f=%h rd=%h sa=%h sh=%h st=%b, want instr=%h p8=%h",
                   cyc, instr_pc, instr, pc_plus8, cond, op, funct, rd, shamt5, sh, shift_type, w, instr_pc + 32'd8);
        end
      end
      ack_en      = ($urandom_range(0, 3) != 0);
      dec_ready   = ($urandom_range(0, 2) != 0);
      br_valid    = ($urandom_range(0, 19) == 0);
      wb_pc_valid = ($urandom_range(0, 29) == 0);
      br_pc       = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      wb_pc       = $urandom;
      redir       = br_valid | wb_pc_valid;
      tgt         = wb_pc_valid ? wb_pc : br_pc;
      tgt         = tgt & 32'hFFFF_FFFC;
      if (dec_valid && dec_ready && !redir) begin
        n_cmp++;
        if (instr_pc !== exp_pc) begin
          n_err++;
          $display("FAIL rnd_order cyc=%0d: got pc=%h, want pc=%h", cyc, instr_pc, exp_pc);
          exp_pc = instr_pc;
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
        gap = 0;
      end else begin
        gap++;
      end
      if (redir) exp_pc = tgt;
      if (gap > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL rnd_stall cyc=%0d: got no delivery for %0d cycles, want at most 300", cyc, gap);
        break;
      end
      prev_wait = imem_req & ~ack_en;
      prev_addr = imem_addr;
    end
    @(negedge clk);
    clear_inputs();
    n_cmp++;
    if (delivered < 200) begin
      n_err++;
      $display("FAIL rnd_throughput: got %0d deliveries, want at least 200", delivered);
    end
    $display("test_random: done, %0d delivered, %0d compared so far", delivered, n_cmp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ack_en = 1'b0;
    dec_ready = 1'b0;
    clear_inputs();
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_drain();
    test_dual_redirect();
    test_redir_ack();
    test_reset_drain_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
